// File: rtl/i2c_target_ctrl.sv
// I2C target controller: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// byte-wide valid/ready RX and TX ports. Open-drain SDA, no clock stretching.
module i2c_target_ctrl #(
    parameter int DATA_SIZE   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 core_clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [6:0]           own_address,
    input  logic                 scl_in,
    input  logic                 sda_in,
    output logic                 sda_oe,
    output logic [DATA_SIZE-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    input  logic [DATA_SIZE-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 busy,
    output logic                 addressed,
    output logic                 rw,
    output logic                 tx_underrun
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ACK_ADDR, S_RX_DATA, S_RX_ACK,
        S_TX_LOAD, S_TX_DATA, S_TX_ACK, S_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic                   r_scl_prev, r_sda_prev;
    logic                   w_scl, w_sda;
    logic                   w_scl_rise, w_scl_fall, w_start, w_stop;

    state_t                 r_state;
    logic [3:0]             r_bit_cnt;
    logic [DATA_SIZE-1:0]   r_shift;
    logic                   r_ack;
    logic                   r_phase;
    logic                   r_sda_oe, r_rx_valid, r_tx_ready, r_busy, r_addressed, r_rw, r_underrun;
    logic [DATA_SIZE-1:0]   r_rx_data;
    logic [DATA_SIZE-1:0]   w_byte;
    logic                   w_last_bit;

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = ~r_scl_prev & w_scl;
    assign w_scl_fall = r_scl_prev & ~w_scl;
    assign w_start    = r_sda_prev & ~w_sda & w_scl;
    assign w_stop     = ~r_sda_prev & w_sda & w_scl;
    assign w_byte     = {r_shift[DATA_SIZE-2:0], w_sda};
    assign w_last_bit = (r_bit_cnt == 4'(DATA_SIZE - 1));

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_ack       <= 1'b0;
            r_phase     <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_tx_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_addressed <= 1'b0;
            r_rw        <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_tx_ready <= 1'b0;
            if (!enable || w_stop) begin
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_addressed <= 1'b0;
                r_sda_oe    <= 1'b0;
            end else if (w_start) begin
                r_state     <= S_ADDR;
                r_bit_cnt   <= '0;
                r_busy      <= 1'b1;
                r_addressed <= 1'b0;
                r_sda_oe    <= 1'b0;
                r_underrun  <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR: if (w_scl_rise) begin
                        r_shift   <= w_byte;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (w_last_bit) begin
                            r_rw    <= w_sda;
                            r_ack   <= 1'b1;
                            r_phase <= 1'b0;
                            if (w_byte[7:1] == own_address) begin
                                r_addressed <= 1'b1;
                                r_state     <= S_ACK_ADDR;
                            end else begin
                                r_state <= S_IGNORE;
                            end
                        end
                    end
                    // First fall drives the 9th bit, second fall releases it and moves on.
                    S_ACK_ADDR, S_RX_ACK: if (w_scl_fall) begin
                        if (!r_phase) begin
                            r_sda_oe <= r_ack;
                            r_phase  <= 1'b1;
                        end else begin
                            r_sda_oe  <= 1'b0;
                            r_phase   <= 1'b0;
                            r_bit_cnt <= '0;
                            r_state   <= (r_state == S_ACK_ADDR && r_rw) ? S_TX_LOAD : S_RX_DATA;
                        end
                    end
                    S_RX_DATA: if (w_scl_rise) begin
                        r_shift   <= w_byte;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (w_last_bit) begin
                            r_phase <= 1'b0;
                            r_state <= S_RX_ACK;
                            r_ack   <= rx_ready;
                            if (rx_ready) begin
                                r_rx_data  <= w_byte;
                                r_rx_valid <= 1'b1;
                            end
                        end
                    end
                    S_TX_LOAD: begin
                        if (tx_valid) begin
                            r_shift    <= tx_data;
                            r_tx_ready <= 1'b1;
                            r_sda_oe   <= ~tx_data[DATA_SIZE-1];
                        end else begin
                            r_shift    <= '1;
                            r_underrun <= 1'b1;
                            r_sda_oe   <= 1'b0;
                        end
                        r_bit_cnt <= '0;
                        r_state   <= S_TX_DATA;
                    end
                    S_TX_DATA: if (w_scl_fall) begin
                        if (w_last_bit) begin
                            r_sda_oe <= 1'b0;
                            r_phase  <= 1'b0;
                            r_state  <= S_TX_ACK;
                        end else begin
                            r_shift   <= {r_shift[DATA_SIZE-2:0], 1'b1};
                            r_sda_oe  <= ~r_shift[DATA_SIZE-2];
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                    S_TX_ACK: begin
                        if (w_scl_rise) begin
                            if (w_sda) r_state <= S_IGNORE;
                            else       r_phase <= 1'b1;
                        end else if (w_scl_fall && r_phase) begin
                            r_phase <= 1'b0;
                            r_state <= S_TX_LOAD;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_oe      = r_sda_oe;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_ready    = r_tx_ready;
    assign busy        = r_busy;
    assign addressed   = r_addressed;
    assign rw          = r_rw;
    assign tx_underrun = r_underrun;

endmodule
